multimode_seq_counter: RTL and testbench

- Parametrised sequence generator that replaces the fixed 3-bit schematic counter (outputs A/B/C) used in the lab flow.
- Supports width, modulus and four run-time counting modes: binary up, binary down, Gray up, Johnson. Also provides enable, synchronous load, a terminal-count flag and a saturating wrap counter.
- Drives LED/seven-segment display logic or serves as a timebase for downstream lab FSMs.

---
 rtl/multimode_seq_counter_if.sv | 16 +
 rtl/multimode_seq_counter.sv | 79 +++++++
 tb/tb_multimode_seq_counter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/multimode_seq_counter_if.sv
// Control/status bundle for multimode_seq_counter: the driver sets the mode and strobes,
// and the counter returns the sequence value, terminal count and wrap count.
interface multimode_seq_counter_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       mode;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic [7:0]       wraps;

    modport master (output en, load, load_val, mode, input q, tc, wraps);
    modport slave  (input en, load, load_val, mode, output q, tc, wraps);
endinterface

// File: rtl/multimode_seq_counter.sv
// Run-time selectable sequence generator (binary up/down, Gray up, Johnson) with load,
// terminal-count flag and a saturating wrap counter.
module multimode_seq_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    multimode_seq_counter_if.slave         bus
);
    typedef enum logic [1:0] {
        M_UP   = 2'b00,
        M_DOWN = 2'b01,
        M_GRAY = 2'b10,
        M_JOHN = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] MAXI    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] JR_TERM = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] jr;
    mode_e            mode_r;
    logic [7:0]       wraps;
    logic             term;
    logic             tc;
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = (bus.load_val > MAXI) ? MAXI : bus.load_val;

    always_comb begin
        term = 1'b0;
        case (mode_r)
            M_UP, M_GRAY: term = (idx == MAXI);
            M_DOWN:       term = (idx == '0);
            M_JOHN:       term = (jr == JR_TERM);
            default:      term = 1'b0;
        endcase
    end

    // TC is gated by a pending mode change or load, since neither of those edges counts.
    assign tc = bus.en && !bus.load && (bus.mode == mode_r) && term;

    always_comb begin
        bus.q = idx;
        case (mode_r)
            M_GRAY:  bus.q = idx ^ (idx >> 1);
            M_JOHN:  bus.q = jr;
            default: bus.q = idx;
        endcase
    end

    assign bus.tc    = tc;
    assign bus.wraps = wraps;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            jr     <= '0;
            mode_r <= M_UP;
            wraps  <= '0;
        end else if (bus.mode != mode_r) begin
            mode_r <= mode_e'(bus.mode);
            idx    <= '0;
            jr     <= '0;
        end else if (bus.load) begin
            idx <= load_clamped;
            jr  <= bus.load_val;
        end else if (bus.en) begin
            case (mode_r)
                M_UP, M_GRAY: idx <= (idx == MAXI) ? '0 : idx + WIDTH'(1);
                M_DOWN:       idx <= (idx == '0) ? MAXI : idx - WIDTH'(1);
                M_JOHN:       jr  <= {jr[WIDTH-2:0], ~jr[WIDTH-1]};
                default:      idx <= idx;
            endcase
            if (tc && wraps != 8'hFF) wraps <= wraps + 8'd1;
        end
    end
endmodule

// File: tb/tb_multimode_seq_counter.sv
// Directed bench: instance A is WIDTH=3/MODULUS=8, instance B is WIDTH=4/MODULUS=6.
module tb_multimode_seq_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multimode_seq_counter_if #(.WIDTH(3)) ifa ();
    multimode_seq_counter_if #(.WIDTH(4)) ifb ();

    multimode_seq_counter #(.WIDTH(3), .MODULUS(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    multimode_seq_counter #(.WIDTH(4), .MODULUS(6)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct {
        bit         sel;
        logic       en;
        logic       load;
        logic [3:0] lv;
        logic [1:0] mode;
        int         q;
        int         tc;
        int         w;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt = 0;
    int   total    = 0;

    function automatic vec_t mk(bit sel, logic en, logic load, logic [3:0] lv, logic [1:0] mode,
                                int q, int tc, int w);
        vec_t v;
        v.sel = sel; v.en = en; v.load = load; v.lv = lv; v.mode = mode;
        v.q = q; v.tc = tc; v.w = w;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic drive(bit sel, logic en, logic load, logic [3:0] lv, logic [1:0] mode);
        if (sel) begin
            ifb.en = en; ifb.load = load; ifb.load_val = lv; ifb.mode = mode;
        end else begin
            ifa.en = en; ifa.load = load; ifa.load_val = lv[2:0]; ifa.mode = mode;
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 2'd0);

        // A: binary up, Gray up, Johnson, then hold
        for (int i = 1; i < 8; i++) vecs.push_back(mk(0, 1, 0, 0, 2'd0, i, (i == 7) ? 1 : 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2'd0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd2, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd2, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd2, 3, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd2, 2, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd2, 6, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd2, 7, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd2, 5, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd2, 4, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2'd2, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 2'd3, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 2'd3, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 2'd3, 3, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 2'd3, 7, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 2'd3, 6, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 2'd3, 4, 1, 2));
        vecs.push_back(mk(0, 1, 0, 0, 2'd3, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 2'd3, 0, 0, 3));
        // B: up one step, switch to down, wrap, clamp load, hold, Johnson with invalid loads
        vecs.push_back(mk(1, 1, 0, 0, 2'd0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 2'd1, 0, 1, 0));
        for (int i = 5; i >= 1; i--) vecs.push_back(mk(1, 1, 0, 0, 2'd1, i, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 2'd1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 2'd1, 5, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 2'd0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 1, 9, 2'd0, 5, 0, 2));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 9, 2'd0, 5, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 2'd0, 0, 0, 3));
        vecs.push_back(mk(1, 1, 0, 0, 2'd3, 0, 0, 3));
        vecs.push_back(mk(1, 1, 1, 5, 2'd3, 5, 0, 3));
        vecs.push_back(mk(1, 1, 0, 0, 2'd3, 11, 0, 3));
        vecs.push_back(mk(1, 1, 1, 8, 2'd3, 8, 0, 3));
        vecs.push_back(mk(1, 0, 0, 0, 2'd3, 8, 0, 3));
        vecs.push_back(mk(1, 1, 0, 0, 2'd3, 0, 0, 4));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_q", int'(ifa.q), 0);
        chk("rst_a_tc", int'(ifa.tc), 0);
        chk("rst_a_wraps", int'(ifa.wraps), 0);
        chk("rst_b_q", int'(ifb.q), 0);
        rst = 1'b0;

        // A pending mode change must suppress TC even though idx==0 is terminal for down
        drive(1'b1, 1'b1, 1'b0, 4'd0, 2'd1);
        #1 chk("b_tc_mode_pending", int'(ifb.tc), 0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 2'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].en, vecs[i].load, vecs[i].lv, vecs[i].mode);
            @(posedge clk);
            #1;
            if (vecs[i].sel) begin
                chk($sformatf("vec%0d_b_q", i), int'(ifb.q), vecs[i].q);
                chk($sformatf("vec%0d_b_tc", i), int'(ifb.tc), vecs[i].tc);
                chk($sformatf("vec%0d_b_wraps", i), int'(ifb.wraps), vecs[i].w);
            end else begin
                chk($sformatf("vec%0d_a_q", i), int'(ifa.q), vecs[i].q);
                chk($sformatf("vec%0d_a_tc", i), int'(ifa.tc), vecs[i].tc);
                chk($sformatf("vec%0d_a_wraps", i), int'(ifa.wraps), vecs[i].w);
            end
        end

        // Asynchronous reset between edges while Q=4
        drive(1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
        @(posedge clk);
        drive(1'b0, 1'b0, 1'b1, 4'd4, 2'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
        chk("async_pre_q", int'(ifa.q), 4);
        chk("async_pre_wraps", int'(ifa.wraps), 3);
        #2 rst = 1'b1;
        #1;
        chk("async_q", int'(ifa.q), 0);
        chk("async_wraps_a", int'(ifa.wraps), 0);
        chk("async_wraps_b", int'(ifb.wraps), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Saturation: one wrap every 8 edges
        drive(1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
        repeat (8 * 255 - 1) @(posedge clk);
        #1;
        chk("sat_254", int'(ifa.wraps), 254);
        chk("sat_tc_q7", int'(ifa.tc), 1);
        @(posedge clk);
        #1;
        chk("sat_255", int'(ifa.wraps), 255);
        repeat (16) @(posedge clk);
        #1;
        chk("sat_hold", int'(ifa.wraps), 255);
        chk("sat_q", int'(ifa.q), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
